// File: rtl/spi_master.sv
// SPI master: one word per transfer, all four {CPOL,CPHA} modes, selectable bit order,
// NUM_CS decoded active-low chip selects. SCLK half-period is DIV clk cycles.
module spi_master #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter int NUM_CS = 2,
  localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [CSW-1:0]    cs_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TOG_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * DATA_W);
  localparam logic [TOG_W-1:0] TOG_ONE  = TOG_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_r;
  logic [DIV_W-1:0]    div_cnt_r;
  logic [TOG_W-1:0]    tog_cnt_r;
  logic [DATA_W-1:0]   tx_sh_r;
  logic [DATA_W-1:0]   rx_sh_r;
  logic [DATA_W-1:0]   rx_data_r;
  logic                cpha_r;
  logic                lsb_r;
  logic                busy_r;
  logic                done_r;
  logic                sclk_r;
  logic                mosi_r;
  logic [NUM_CS-1:0]   cs_n_r;

  logic                div_last_s;
  logic [TOG_W-1:0]    tog_num_s;
  logic                toggle_s;
  logic                sample_s;
  logic                advance_s;
  logic [DATA_W-1:0]   tx_next_s;
  logic                mosi_next_s;
  logic [DATA_W-1:0]   rx_next_s;
  logic [NUM_CS-1:0]   cs_dec_s;

  // Edge scheduling: toggle number tog_num_s is 1-based, odd toggles are leading edges.
  always_comb begin
    div_last_s = (div_cnt_r == DIV_LAST);
    tog_num_s  = tog_cnt_r + TOG_ONE;
    if (state_r == SETUP) begin
      toggle_s = div_last_s;
    end else if (state_r == XFER) begin
      toggle_s = div_last_s && (tog_cnt_r != TOG_LAST);
    end else begin
      toggle_s = 1'b0;
    end
    if (cpha_r) begin
      sample_s  = ~tog_num_s[0];
      advance_s = tog_num_s[0] && (tog_num_s != TOG_ONE);
    end else begin
      sample_s  = tog_num_s[0];
      advance_s = ~tog_num_s[0] && (tog_num_s != TOG_LAST);
    end
  end

  // Shift datapath for the selected bit order.
  always_comb begin
    if (lsb_r) begin
      tx_next_s   = {1'b0, tx_sh_r[DATA_W-1:1]};
      mosi_next_s = tx_sh_r[1];
      rx_next_s   = {miso, rx_sh_r[DATA_W-1:1]};
    end else begin
      tx_next_s   = {tx_sh_r[DATA_W-2:0], 1'b0};
      mosi_next_s = tx_sh_r[DATA_W-2];
      rx_next_s   = {rx_sh_r[DATA_W-2:0], miso};
    end
  end

  // Chip-select decode; an out-of-range index leaves every line high.
  always_comb begin
    cs_dec_s = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CSW'(i)) begin
        cs_dec_s[i] = 1'b0;
      end else begin
        cs_dec_s[i] = 1'b1;
      end
    end
  end

  // Transfer FSM with registered serial and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      tog_cnt_r <= '0;
      tx_sh_r   <= '0;
      rx_sh_r   <= '0;
      rx_data_r <= '0;
      cpha_r    <= 1'b0;
      lsb_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_n_r    <= '1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= SETUP;
            busy_r    <= 1'b1;
            cpha_r    <= mode[0];
            sclk_r    <= mode[1];
            lsb_r     <= lsb_first;
            tx_sh_r   <= tx_data;
            rx_sh_r   <= '0;
            mosi_r    <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
            cs_n_r    <= cs_dec_s;
            div_cnt_r <= '0;
            tog_cnt_r <= '0;
          end
        end
        SETUP: begin
          if (div_last_s) begin
            state_r   <= XFER;
            div_cnt_r <= '0;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        XFER: begin
          if (div_last_s) begin
            div_cnt_r <= '0;
            if (tog_cnt_r == TOG_LAST) begin
              state_r <= HOLD;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        HOLD: begin
          if (div_last_s) begin
            state_r   <= IDLE;
            div_cnt_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            cs_n_r    <= '1;
            mosi_r    <= 1'b0;
            rx_data_r <= rx_sh_r;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (toggle_s) begin
        sclk_r    <= ~sclk_r;
        tog_cnt_r <= tog_num_s;
        if (sample_s) begin
          rx_sh_r <= rx_next_s;
        end
        if (advance_s) begin
          tx_sh_r <= tx_next_s;
          mosi_r  <= mosi_next_s;
        end
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;
  assign sclk    = sclk_r;
  assign mosi    = mosi_r;
  assign cs_n    = cs_n_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an 8-bit/DIV=2 instance with a slave model and
// a 16-bit/DIV=1/3-select instance in loopback.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, lsb1, cs1, busy1, done1, sclk1, mosi1, miso1, loop1;
  logic [7:0]  tx1, rx1;
  logic [1:0]  mode1, csn1;
  logic        start2, lsb2, busy2, done2, sclk2, mosi2;
  logic [15:0] tx2, rx2;
  logic [1:0]  mode2, cs2;
  logic [2:0]  csn2;

  spi_master #(.DATA_W(8), .DIV(2), .NUM_CS(2)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .mode(mode1),
    .lsb_first(lsb1), .cs_sel(cs1), .busy(busy1), .done(done1), .rx_data(rx1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(csn1));

  spi_master #(.DATA_W(16), .DIV(1), .NUM_CS(3)) u_dut16 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx2), .mode(mode2),
    .lsb_first(lsb2), .cs_sel(cs2), .busy(busy2), .done(done2), .rx_data(rx2),
    .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .cs_n(csn2));

  // Slave / line monitor for the 8-bit instance
  logic       mon_en = 1'b0, mon_lsb = 1'b0, mon_cpha = 1'b0, slv_miso;
  logic [7:0] slv_word = 8'h00, mon_word = 8'h00;
  logic [2:0] slv_idx = 3'd0;
  logic       sclk_prev = 1'b0;
  int         tcount = 0, rises1 = 0;

  always_comb slv_miso = mon_lsb ? slv_word[slv_idx] : slv_word[3'd7 - slv_idx];
  assign miso1 = loop1 ? mosi1 : slv_miso;

  always @(sclk1 or mon_en) begin
    if (!mon_en) begin
      tcount = 0; rises1 = 0; mon_word = 8'h00; slv_idx = 3'd0;
    end else if (sclk1 !== sclk_prev) begin
      tcount = tcount + 1;
      if (sclk1) rises1 = rises1 + 1;
      if ((tcount % 2 == 1) ^ mon_cpha)
        mon_word = mon_lsb ? {mosi1, mon_word[7:1]} : {mon_word[6:0], mosi1};
      else if (tcount / 2 < 8)
        slv_idx = 3'(tcount / 2);
    end
    sclk_prev = sclk1;
  end

  logic mon2_en = 1'b0;
  int   rises2 = 0;
  always @(posedge sclk2 or negedge mon2_en) begin
    if (!mon2_en) rises2 = 0;
    else rises2 = rises2 + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // n is the cycle index relative to the start cycle T (caller is in T+1)
  task automatic wait_done(input bit sel, input int limit, output int n);
    n = 1;
    while (((sel ? done2 : done1) !== 1'b1) && n < limit) begin
      tick();
      n++;
    end
  endtask

  typedef struct packed {
    logic [1:0] mode;
    logic       lsb;
    logic       cs;
    logic [7:0] tx;
    logic       loop;
    logic [7:0] slv;
    logic [7:0] exp_rx;
    logic [1:0] exp_csn;
    logic       exp_first;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n, nd, first;
    logic ok;
    vecs[0] = '{2'b00, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 8'hA5, 2'b10, 1'b1};
    vecs[1] = '{2'b11, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h96, 8'h96, 2'b01, 1'b0};
    vecs[2] = '{2'b01, 1'b0, 1'b0, 8'h5A, 1'b0, 8'hC3, 8'hC3, 2'b10, 1'b0};
    vecs[3] = '{2'b10, 1'b1, 1'b1, 8'h81, 1'b1, 8'h00, 8'h81, 2'b01, 1'b1};

    rst = 1'b1; start1 = 1'b0; tx1 = 8'h00; mode1 = 2'b00; lsb1 = 1'b0; cs1 = 1'b0; loop1 = 1'b1;
    start2 = 1'b0; tx2 = 16'h0000; mode2 = 2'b00; lsb2 = 1'b0; cs2 = 2'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_rx", rx1, 8'h00);
    chk("rst_sclk", sclk1, 1'b0);
    chk("rst_mosi", mosi1, 1'b0);
    chk("rst_csn", csn1, 2'b11);
    chk("rst_csn16", csn2, 3'b111);
    chk("rst_busy16", busy2, 1'b0);

    // Abort by reset at T+10; start held with reset to check priority
    mode1 = 2'b00; lsb1 = 1'b0; cs1 = 1'b0; tx1 = 8'hA5; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("abort_busy_t1", busy1, 1'b1);
    chk("abort_csn_t1", csn1, 2'b10);
    repeat (9) tick();
    rst = 1'b1; start1 = 1'b1;
    tick();
    rst = 1'b0; start1 = 1'b0;
    chk("abort_busy", busy1, 1'b0);
    chk("abort_csn", csn1, 2'b11);
    chk("abort_rx", rx1, 8'h00);
    chk("abort_sclk", sclk1, 1'b0);
    nd = 0;
    repeat (40) begin
      tick();
      if (done1) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle_busy", busy1, 1'b0);

    // Table-driven transfers on the 8-bit instance
    for (int i = 0; i < 4; i++) begin
      mode1 = vecs[i].mode; lsb1 = vecs[i].lsb; cs1 = vecs[i].cs; tx1 = vecs[i].tx;
      loop1 = vecs[i].loop; slv_word = vecs[i].slv;
      mon_lsb = vecs[i].lsb; mon_cpha = vecs[i].mode[0];
      start1 = 1'b1;
      tick();
      start1 = 1'b0; tx1 = ~vecs[i].tx; cs1 = ~vecs[i].cs; mode1 = ~vecs[i].mode; lsb1 = ~vecs[i].lsb;
      chk($sformatf("v%0d_busy", i), busy1, 1'b1);
      chk($sformatf("v%0d_csn", i), csn1, vecs[i].exp_csn);
      chk($sformatf("v%0d_sclk_setup", i), sclk1, vecs[i].mode[1]);
      chk($sformatf("v%0d_first_mosi", i), mosi1, vecs[i].exp_first);
      mon_en = 1'b1;
      wait_done(1'b0, 60, n);
      chk($sformatf("v%0d_done_cycle", i), n, 37);
      chk($sformatf("v%0d_rx", i), rx1, vecs[i].exp_rx);
      chk($sformatf("v%0d_busy_end", i), busy1, 1'b0);
      chk($sformatf("v%0d_csn_end", i), csn1, 2'b11);
      chk($sformatf("v%0d_mosi_idle", i), mosi1, 1'b0);
      chk($sformatf("v%0d_sclk_idle", i), sclk1, vecs[i].mode[1]);
      tick();
      chk($sformatf("v%0d_done_pulse", i), done1, 1'b0);
      chk($sformatf("v%0d_rises", i), rises1, 8);
      chk($sformatf("v%0d_mosi_word", i), mon_word, vecs[i].tx);
      mon_en = 1'b0;
    end

    // Start pulsed at T+5 while busy must be ignored
    mode1 = 2'b00; lsb1 = 1'b0; cs1 = 1'b0; tx1 = 8'h6B; loop1 = 1'b1;
    mon_lsb = 1'b0; mon_cpha = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0; mon_en = 1'b1;
    nd = 0; first = 0;
    for (int k = 2; k <= 45; k++) begin
      tick();
      start1 = (k == 5);
      tx1 = (k == 5) ? 8'hFF : 8'h6B;
      if (done1) begin
        nd++;
        if (first == 0) first = k;
      end
    end
    chk("busystart_done_cycle", first, 37);
    chk("busystart_done_count", nd, 1);
    chk("busystart_rx", rx1, 8'h6B);
    chk("busystart_mosi_word", mon_word, 8'h6B);
    chk("busystart_idle", busy1, 1'b0);
    mon_en = 1'b0;

    // Back-to-back transfers on the 16-bit instance
    mode2 = 2'b01; lsb2 = 1'b0; cs2 = 2'd0; tx2 = 16'h1234; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("b2b_csn", csn2, 3'b110);
    chk("b2b_busy", busy2, 1'b1);
    wait_done(1'b1, 60, n);
    chk("b2b_first_done", n, 35);
    chk("b2b_first_rx", rx2, 16'h1234);
    first = n;
    tx2 = 16'hBEEF; start2 = 1'b1;
    tick();
    start2 = 1'b0; tx2 = 16'h0000;
    chk("b2b_busy2", busy2, 1'b1);
    chk("b2b_sclk_cpol", sclk2, 1'b0);
    wait_done(1'b1, 60, n);
    chk("b2b_second_done", first + n, 70);
    chk("b2b_second_rx", rx2, 16'hBEEF);

    // Out-of-range chip select still runs the transfer
    mode2 = 2'b00; cs2 = 2'd3; tx2 = 16'hC0DE; start2 = 1'b1;
    tick();
    start2 = 1'b0; mon2_en = 1'b1;
    ok = 1'b1; n = 1;
    while (done2 !== 1'b1 && n < 60) begin
      if (csn2 !== 3'b111) ok = 1'b0;
      tick();
      n++;
    end
    chk("cs3_csn_high", {ok, csn2}, {1'b1, 3'b111});
    chk("cs3_done", n, 35);
    chk("cs3_rx", rx2, 16'hC0DE);
    chk("cs3_rises", rises2, 16);
    mon2_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
